// File: rtl/red_pitaya_iq_sweep_sequencer_pkg.sv
// Shared constants and types for the IQ frequency-sweep sequencer.
// Covers the IQ block register map, the sum-word busy flag and the sequencer states.
package red_pitaya_iq_sweep_sequencer_pkg;

    localparam logic [15:0] IQ_ADDR_FREQ = 16'h0108;
    localparam logic [15:0] IQ_ADDR_I_LO = 16'h0140;
    localparam logic [15:0] IQ_ADDR_I_HI = 16'h0144;
    localparam logic [15:0] IQ_ADDR_Q_LO = 16'h0148;
    localparam logic [15:0] IQ_ADDR_Q_HI = 16'h014C;

    localparam int unsigned IQ_BUSY_BIT = 31;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_FREQ,
        ST_WR_ACK,
        ST_POLL,
        ST_POLL_ACK,
        ST_RD,
        ST_RD_ACK,
        ST_PUSH
    } sweep_state_t;

    // Sum word k (0..3) lives at I_LO + 4*k.
    function automatic logic [15:0] sum_addr(input logic [1:0] k);
        return IQ_ADDR_I_LO + {12'd0, k, 2'b00};
    endfunction

endpackage

// File: rtl/red_pitaya_iq_sweep_sequencer_if.sv
// Register-port bus between the sweep sequencer (master) and the IQ block (slave).
interface red_pitaya_iq_sweep_sequencer_if;
    import red_pitaya_iq_sweep_sequencer_pkg::*;

    logic [15:0] addr;
    logic        wen;
    logic        ren;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output addr, wen, ren, wdata, input ack, rdata);
    modport slave  (input addr, wen, ren, wdata, output ack, rdata);

endinterface

// File: rtl/red_pitaya_iq_sweep_sequencer_iq_bus_master.sv
// Single-transaction engine: drives one strobe cycle, then watches for the ack
// and flags a timeout when it does not arrive within ACK_TIMEOUT wait cycles.
module iq_bus_master
    import red_pitaya_iq_sweep_sequencer_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        issue_i,
    input  logic        wr_i,
    input  logic [15:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        wait_i,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        timeout_o,
    red_pitaya_iq_sweep_sequencer_if.master bus
);

    localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);

    logic [CW-1:0] cnt_q;

    assign bus.wen   = issue_i & wr_i;
    assign bus.ren   = issue_i & ~wr_i;
    assign bus.addr  = issue_i ? addr_i : '0;
    assign bus.wdata = (issue_i & wr_i) ? wdata_i : '0;

    // Acks outside a wait state are ignored.
    assign ack_o     = wait_i & bus.ack;
    assign rdata_o   = bus.rdata;
    assign timeout_o = wait_i & ~bus.ack & (cnt_q == CW'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (!rstn_i || !wait_i || bus.ack) begin
            cnt_q <= '0;
        end else if (!timeout_o) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/red_pitaya_iq_sweep_sequencer.sv
// Frequency-sweep sequencer: per point writes the IQ frequency, polls for end of
// averaging, reads the split I/Q sums and streams them out with valid/ready.
module red_pitaya_iq_sweep_sequencer
    import red_pitaya_iq_sweep_sequencer_pkg::*;
#(
    parameter int unsigned PHASEBITS   = 32,
    parameter int unsigned NPTBITS     = 16,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [PHASEBITS-1:0] start_freq_i,
    input  logic [PHASEBITS-1:0] step_freq_i,
    input  logic [NPTBITS-1:0]   n_points_i,
    red_pitaya_iq_sweep_sequencer_if.master iq,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [61:0]          res_i_o,
    output logic [61:0]          res_q_o,
    output logic [NPTBITS-1:0]   res_idx_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);

    sweep_state_t state_q, state_d;

    logic [PHASEBITS-1:0] freq_q, step_q;
    logic [NPTBITS-1:0]   npts_q, idx_q;
    logic [1:0]           k_q;
    logic [3:0][30:0]     words_q;
    logic                 err_q, done_q;

    logic        issue, wr, wait_ack, ack, timeout;
    logic [15:0] addr;
    logic [31:0] rdata;
    logic        accept_start, handshake, last;

    assign accept_start = (state_q == ST_IDLE) & start_i & ~abort_i;
    assign handshake    = (state_q == ST_PUSH) & res_ready_i & ~abort_i;
    assign last         = (idx_q == npts_q - NPTBITS'(1));

    iq_bus_master #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_bus (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .issue_i   (issue),
        .wr_i      (wr),
        .addr_i    (addr),
        .wdata_i   (32'(freq_q)),
        .wait_i    (wait_ack),
        .ack_o     (ack),
        .rdata_o   (rdata),
        .timeout_o (timeout),
        .bus       (iq)
    );

    always_ff @(posedge clk_i) begin
        if (!rstn_i) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        issue    = 1'b0;
        wr       = 1'b0;
        addr     = '0;
        wait_ack = 1'b0;
        case (state_q)
            ST_IDLE: if (start_i && n_points_i != '0) state_d = ST_WR_FREQ;
            ST_WR_FREQ: begin
                issue   = 1'b1;
                wr      = 1'b1;
                addr    = IQ_ADDR_FREQ;
                state_d = ST_WR_ACK;
            end
            ST_WR_ACK: begin
                wait_ack = 1'b1;
                if (ack)          state_d = ST_POLL;
                else if (timeout) state_d = ST_IDLE;
            end
            ST_POLL: begin
                issue   = 1'b1;
                addr    = IQ_ADDR_I_LO;
                state_d = ST_POLL_ACK;
            end
            ST_POLL_ACK: begin
                wait_ack = 1'b1;
                if (ack)          state_d = rdata[IQ_BUSY_BIT] ? ST_POLL : ST_RD;
                else if (timeout) state_d = ST_IDLE;
            end
            ST_RD: begin
                issue   = 1'b1;
                addr    = sum_addr(k_q);
                state_d = ST_RD_ACK;
            end
            ST_RD_ACK: begin
                wait_ack = 1'b1;
                if (ack)          state_d = (k_q == 2'd3) ? ST_PUSH : ST_RD;
                else if (timeout) state_d = ST_IDLE;
            end
            ST_PUSH: if (res_ready_i) state_d = last ? ST_IDLE : ST_WR_FREQ;
            default: state_d = ST_IDLE;
        endcase
        // Abort wins over everything, and also suppresses this cycle's strobe.
        if (abort_i) begin
            state_d = ST_IDLE;
            issue   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            freq_q  <= '0;
            step_q  <= '0;
            npts_q  <= '0;
            idx_q   <= '0;
            k_q     <= '0;
            words_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept_start) begin
                freq_q <= start_freq_i;
                step_q <= step_freq_i;
                npts_q <= n_points_i;
                idx_q  <= '0;
                err_q  <= 1'b0;
                done_q <= (n_points_i == '0);
            end
            if (!abort_i) begin
                if (state_q == ST_POLL_ACK && ack && !rdata[IQ_BUSY_BIT]) begin
                    words_q[0] <= rdata[30:0];
                    k_q        <= 2'd1;
                end
                if (state_q == ST_RD_ACK && ack) begin
                    words_q[k_q] <= rdata[30:0];
                    k_q          <= k_q + 2'd1;
                end
                if (timeout) err_q <= 1'b1;
            end
            if (handshake) begin
                if (last) begin
                    done_q <= 1'b1;
                end else begin
                    freq_q <= freq_q + step_q;
                    idx_q  <= idx_q + NPTBITS'(1);
                end
            end
        end
    end

    assign res_valid_o = (state_q == ST_PUSH) & ~abort_i;
    assign res_i_o     = {words_q[1], words_q[0]};
    assign res_q_o     = {words_q[3], words_q[2]};
    assign res_idx_o   = idx_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_red_pitaya_iq_sweep_sequencer.sv
// Bench for the IQ sweep sequencer: behavioural IQ block with averaging delay and
// random sums, scoreboard of written frequencies and returned results.
module tb_red_pitaya_iq_sweep_sequencer;

    localparam int AVG_CYCLES = 10;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] start_freq = '0;
    logic [31:0] step_freq = '0;
    logic [15:0] n_points = '0;
    logic        res_ready = 1'b1;
    logic        res_valid, busy, done, err;
    logic [61:0] res_i, res_q;
    logic [15:0] res_idx;

    int checks = 0;
    int errors = 0;

    red_pitaya_iq_sweep_sequencer_if iq ();

    red_pitaya_iq_sweep_sequencer #(
        .PHASEBITS(32), .NPTBITS(16), .ACK_TIMEOUT(15)
    ) dut (
        .clk_i(clk), .rstn_i(rstn), .start_i(start), .abort_i(abort),
        .start_freq_i(start_freq), .step_freq_i(step_freq), .n_points_i(n_points),
        .iq(iq), .res_valid_o(res_valid), .res_ready_i(res_ready),
        .res_i_o(res_i), .res_q_o(res_q), .res_idx_o(res_idx),
        .busy_o(busy), .done_o(done), .err_o(err)
    );

    always #5 clk = ~clk;

    // IQ block model: a frequency write restarts averaging with fresh sums.
    int          avg_cnt = 0;
    int          polls = 0;
    int          withhold_poll = 0;
    bit          force_sums = 1'b0;
    logic [61:0] cur_i = '0, cur_q = '0;
    logic [31:0] m_wr[$];
    logic [61:0] m_i[$], m_q[$];

    always @(posedge clk) begin
        logic [63:0] r1, r2;
        logic        bsy;
        iq.ack <= 1'b0;
        if (avg_cnt > 0) avg_cnt--;
        if (iq.wen) begin
            r1 = {$urandom, $urandom};
            r2 = {$urandom, $urandom};
            cur_i = force_sums ? '1 : r1[61:0];
            cur_q = force_sums ? {31'h2AAAAAAA, 31'h55555555} : r2[61:0];
            m_wr.push_back(iq.wdata);
            m_i.push_back(cur_i);
            m_q.push_back(cur_q);
            avg_cnt = AVG_CYCLES;
            polls   = 0;
            iq.ack <= 1'b1;
        end else if (iq.ren) begin
            bsy = (avg_cnt != 0);
            if (iq.addr == 16'h0140) polls++;
            iq.ack <= !(iq.addr == 16'h0140 && polls == withhold_poll);
            case (iq.addr)
                16'h0140: iq.rdata <= {bsy, cur_i[30:0]};
                16'h0144: iq.rdata <= {bsy, cur_i[61:31]};
                16'h0148: iq.rdata <= {bsy, cur_q[30:0]};
                16'h014C: iq.rdata <= {bsy, cur_q[61:31]};
                default:  iq.rdata <= '0;
            endcase
        end
    end

    // Observation at the falling edge, away from the active edge.
    int          strobe_cnt = 0, both_cnt = 0, done_cnt = 0;
    logic [61:0] got_i[$], got_q[$];
    logic [15:0] got_idx[$];

    always @(negedge clk) begin
        if (iq.wen || iq.ren) strobe_cnt++;
        if (iq.wen && iq.ren) both_cnt++;
        if (res_valid && res_ready) begin
            got_i.push_back(res_i);
            got_q.push_back(res_q);
            got_idx.push_back(res_idx);
        end
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at cycle 1 (one edge after start was sampled).
    task automatic start_pulse(input logic [31:0] f, input logic [31:0] s, input logic [15:0] n,
                               input bit with_abort);
        tick();
        start = 1'b1; abort = with_abort;
        start_freq = f; step_freq = s; n_points = n;
        tick();
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic run_sweep(input logic [31:0] f, input logic [31:0] s, input int n,
                             input int stall_idx, input bit rand_ready, input bit timing);
        int          rb, wb, db, stall_n, bad, snap_s;
        logic [61:0] snap_i, snap_q;
        logic [31:0] ef;
        rb = got_i.size(); wb = m_wr.size(); db = done_cnt;
        stall_n = 0; bad = 0; snap_s = 0; snap_i = '0; snap_q = '0;
        res_ready = 1'b1;
        start_pulse(f, s, 16'(n), 1'b0);
        chk("err_cleared_on_start", err, 0);
        if (timing) begin
            chk("c1_wen", iq.wen, 1);
            chk("c1_addr", iq.addr, 16'h0108);
            chk("c1_wdata", iq.wdata, f);
            tick();
            chk("c2_no_strobe", iq.wen | iq.ren, 0);
            tick();
            chk("c3_poll_ren", iq.ren, 1);
            chk("c3_poll_addr", iq.addr, 16'h0140);
        end
        for (int c = 0; c < 4000 && busy; c++) begin
            if (stall_n > 0 && stall_n < 50) begin
                if (!res_valid || res_i !== snap_i || res_q !== snap_q ||
                    int'(res_idx) != stall_idx || strobe_cnt != snap_s) bad++;
                res_ready = 1'b0;
                stall_n++;
            end else if (stall_n == 0 && res_valid && int'(res_idx) == stall_idx) begin
                snap_i = res_i; snap_q = res_q; snap_s = strobe_cnt;
                res_ready = 1'b0;
                stall_n = 1;
            end else begin
                res_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            tick();
        end
        res_ready = 1'b1;
        chk("sweep_finished", busy, 0);
        tick();
        chk("n_results", got_i.size() - rb, n);
        chk("n_writes", m_wr.size() - wb, n);
        for (int p = 0; p < n && rb + p < got_i.size() && wb + p < m_wr.size(); p++) begin
            ef = f + 32'(p) * s;
            chk($sformatf("freq_%0d", p), m_wr[wb + p], ef);
            chk($sformatf("idx_%0d", p), got_idx[rb + p], p);
            chk($sformatf("sum_i_%0d", p), got_i[rb + p], m_i[wb + p]);
            chk($sformatf("sum_q_%0d", p), got_q[rb + p], m_q[wb + p]);
        end
        chk("done_once", done_cnt - db, 1);
        chk("err_clear", err, 0);
        if (stall_idx >= 0 && stall_idx < n) begin
            chk("stall_length", stall_n, 50);
            chk("stall_stable", bad, 0);
        end
    endtask

    initial begin
        int          db, sb, k, np;
        logic [61:0] ones;
        ones = '1;

        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_outs", {res_valid, done, err, iq.wen, iq.ren}, 0);
        chk("rst_addr", iq.addr, 0);
        rstn = 1'b1;
        tick();

        // Directed sweep with a 50-cycle consumer stall at point 1.
        run_sweep(32'd1000, 32'd100, 3, 1, 1'b0, 1'b1);

        // Frequency accumulator wraps silently.
        sb = m_wr.size();
        run_sweep(32'hFFFFFFF0, 32'h20, 2, -1, 1'b1, 1'b0);
        chk("wrap_second_write", (m_wr.size() > sb + 1) ? m_wr[sb + 1] : 32'hDEAD, 32'h10);

        for (int t = 0; t < 3; t++)
            run_sweep($urandom, $urandom, $urandom_range(1, 4), (t == 1) ? 0 : -1, 1'b1, 1'b0);

        // Missing ack on the second poll.
        withhold_poll = 2;
        db = done_cnt;
        start_pulse(32'd5000, 32'd10, 16'd1, 1'b0);
        np = 0;
        for (int c = 0; c < 200 && np < 2; c++) begin
            if (iq.ren && iq.addr == 16'h0140) np++;
            if (np < 2) tick();
        end
        chk("second_poll_seen", np, 2);
        for (k = 1; k <= 40; k++) begin
            tick();
            if (err) break;
        end
        chk("timeout_latency", k, 16);
        chk("timeout_err", err, 1);
        chk("timeout_idle", busy, 0);
        tick();
        chk("timeout_no_done", done_cnt - db, 0);
        withhold_poll = 0;
        run_sweep($urandom, 32'd7, 1, -1, 1'b0, 1'b0);

        // Abort during POLL, together with a new start.
        db = done_cnt;
        start_pulse(32'd2000, 32'd1, 16'd3, 1'b0);
        np = 0;
        for (int c = 0; c < 50 && np == 0; c++) begin
            if (iq.ren && iq.addr == 16'h0140) np = 1;
            else tick();
        end
        chk("abort_poll_seen", np, 1);
        sb = strobe_cnt;
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        chk("abort_idle", busy, 0);
        chk("abort_valid", res_valid, 0);
        repeat (20) tick();
        chk("abort_no_strobes", strobe_cnt - sb, 0);
        chk("abort_no_done", done_cnt - db, 0);
        chk("abort_still_idle", busy, 0);
        chk("abort_err_unchanged", err, 0);

        // Zero-point sweep.
        sb = strobe_cnt;
        start_pulse(32'd123, 32'd1, 16'd0, 1'b0);
        chk("n0_done_c1", done, 1);
        chk("n0_busy", busy, 0);
        tick();
        chk("n0_done_c2", done, 0);
        repeat (5) tick();
        chk("n0_no_strobes", strobe_cnt - sb, 0);

        // All-ones I sum reassembled from two 31-bit words.
        force_sums = 1'b1;
        run_sweep(32'd42, 32'd0, 1, -1, 1'b0, 1'b0);
        force_sums = 1'b0;
        chk("sum_i_all_ones", (got_i.size() > 0) ? got_i[got_i.size() - 1] : 62'd0, ones);
        chk("sum_q_pattern", (got_q.size() > 0) ? got_q[got_q.size() - 1] : 62'd0,
            {31'h2AAAAAAA, 31'h55555555});

        chk("never_both_strobes", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
